// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : button_conditioner
// Purpose  : Per-channel synchronizer, debouncer and press/release pulse
//            generator. Optional auto-repeat with `define BTN_AUTOREPEAT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module button_conditioner #(
    parameter int N_BTN           = 4,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int REPEAT_DELAY    = 20000000,
    parameter int REPEAT_PERIOD   = 4000000
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

`ifdef BTN_AUTOREPEAT_EN
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);
    localparam logic [c_RPT_W-1:0] c_RPT_DELAY_LAST  = c_RPT_W'(REPEAT_DELAY - 1);
    localparam logic [c_RPT_W-1:0] c_RPT_PERIOD_LAST = c_RPT_W'(REPEAT_PERIOD - 1);
`endif

    logic [N_BTN-1:0] r_sync1;
    logic [N_BTN-1:0] r_sync2;

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
        logic [c_CNT_W-1:0] r_cnt;
        logic               r_level;
        logic               r_press;
        logic               r_release;
        logic               w_differs;
        logic               w_toggle;
        logic               w_repeat;

        assign w_differs = r_sync2[gi] ^ r_level;
        // The D-th consecutive differing cycle flips the level instead of counting on.
        assign w_toggle  = w_differs && (r_cnt == c_CNT_LAST);

        always_ff @(posedge pclk or posedge rst) begin
            if (rst) begin
                r_cnt     <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                if (!w_differs || w_toggle) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
                r_level   <= r_level ^ w_toggle;
                r_press   <= (w_toggle & ~r_level) | w_repeat;
                r_release <= w_toggle & r_level;
            end
        end

`ifdef BTN_AUTOREPEAT_EN
        logic [c_RPT_W-1:0] r_rpt;
        logic               r_rpt_again;
        logic [c_RPT_W-1:0] w_rpt_last;

        // r_rpt counts cycles since the last press pulse; first interval is the delay.
        assign w_rpt_last = r_rpt_again ? c_RPT_PERIOD_LAST : c_RPT_DELAY_LAST;
        assign w_repeat   = r_level && !w_toggle && (r_rpt == w_rpt_last);

        always_ff @(posedge pclk or posedge rst) begin
            if (rst) begin
                r_rpt       <= '0;
                r_rpt_again <= 1'b0;
            end else if (!r_level || w_toggle) begin
                r_rpt       <= '0;
                r_rpt_again <= 1'b0;
            end else if (w_repeat) begin
                r_rpt       <= '0;
                r_rpt_again <= 1'b1;
            end else begin
                r_rpt <= r_rpt + 1'b1;
            end
        end
`else
        assign w_repeat = 1'b0;
`endif

        assign btn_level[gi]   = r_level;
        assign btn_press[gi]   = r_press;
        assign btn_release[gi] = r_release;
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter N_BTN, default 4: number of independent button channels (LEFT, RIGHT, START, Restart).
REQ-002 The block SHALL have parameter DEBOUNCE_CYCLES, default 400000: consecutive stable cycles needed to accept a change (10 ms at 40 MHz); legal range 2 or more.
REQ-003 The block SHALL have parameter REPEAT_DELAY, default 20000000: cycles held before the first auto-repeat pulse; used only with BTN_AUTOREPEAT_EN.
REQ-004 The block SHALL have parameter REPEAT_PERIOD, default 4000000: cycles between subsequent auto-repeat pulses; used only with BTN_AUTOREPEAT_EN.
REQ-005 The block SHALL have port pclk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 The block SHALL have port btn_raw, input, N_BTN bits: raw, asynchronous, bouncing button levels (1 = pressed).
REQ-008 The block SHALL have port btn_level, output, N_BTN bits: debounced, registered button level.
REQ-009 The block SHALL have port btn_press, output, N_BTN bits: 1-cycle pulse per accepted press (plus repeats when enabled).
REQ-010 The block SHALL have port btn_release, output, N_BTN bits: 1-cycle pulse per accepted release.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use; no other logic SHALL read btn_raw.
REQ-012 Each channel SHALL have a counter sized to $clog2(DEBOUNCE_CYCLES) bits; the counter clears on any cycle where the synchronized input equals btn_level.
REQ-013 The counter SHALL increment on each cycle where the synchronized input differs from btn_level.
REQ-014 On the cycle the counter would reach DEBOUNCE_CYCLES, btn_level SHALL toggle and the counter SHALL clear; the counter never wraps.
REQ-015 Latency SHALL be exactly DEBOUNCE_CYCLES+2 rising edges: raw change sampled at edge 0 -> btn_level changes after edge DEBOUNCE_CYCLES+1.
REQ-016 A glitch or bounce shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change btn_level and SHALL NOT produce any pulse.
REQ-017 btn_press[i] SHALL be registered and high for exactly the one cycle in which btn_level[i] first reads 1.
REQ-018 btn_release[i] SHALL be registered and high for exactly the one cycle in which btn_level[i] first reads 0.
REQ-019 Channels SHALL be fully independent; simultaneous events on several channels SHALL produce simultaneous pulses.
REQ-020 btn_press and btn_release SHALL never both be high on the same channel in the same cycle.

Reset
REQ-021 While rst=1, synchronizers, counters, btn_level, btn_press, btn_release and repeat counters SHALL all be 0, asynchronously.
REQ-022 Reset asserted mid-debounce or while a button is held SHALL discard the in-progress state and SHALL NOT emit a btn_release pulse.
REQ-023 After reset release with a button held, that channel SHALL emit btn_press after the normal REQ-015 latency.

Configuration
REQ-024 Macro BTN_AUTOREPEAT_EN SHALL enable auto-repeat; when it is defined, a per-channel repeat counter runs while btn_level[i]=1.
REQ-025 With BTN_AUTOREPEAT_EN defined, extra btn_press pulses SHALL fire REPEAT_DELAY cycles after the initial press pulse, then every REPEAT_PERIOD cycles while held.
REQ-026 With BTN_AUTOREPEAT_EN defined, the repeat counter SHALL clear on release or reset.
REQ-027 Without BTN_AUTOREPEAT_EN, repeat logic SHALL be absent, REPEAT_* parameters SHALL be ignored, and exactly one btn_press pulse SHALL occur per accepted press.

Verification
REQ-028 Scenario (DEBOUNCE_CYCLES=4): btn_raw[0] 0->1 held -> btn_level[0]=1 and btn_press[0] 1-cycle pulse, both 6 edges after the sampling edge.
REQ-029 Scenario (DEBOUNCE_CYCLES=4): bounce 1,0,1,0 at 1-cycle spacing, then stable 1 -> single btn_press only after 4 stable synchronized cycles.
REQ-030 Scenario: 3-cycle glitch on btn_raw[2] with DEBOUNCE_CYCLES=4 -> btn_level unchanged, no pulses.
REQ-031 Scenario: btn_raw=4'b1010 set in one cycle -> btn_press=4'b1010 in the same cycle; later release of both -> btn_release=4'b1010 in the same cycle.
REQ-032 Scenario: rst pulsed while btn_level[1]=1 -> all outputs 0 at once, no release pulse; button still held -> btn_press[1] 6 edges after rst deasserts.
REQ-033 Scenario (BTN_AUTOREPEAT_EN, DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, held 20 cycles past press) -> press pulses at offsets 0, 10, 13, 16, 19.
